synthesijer_fcomp64_axis_core: RTL

Native-RTL double-precision floating-point comparator that terminates the AXI4-Stream compare interface: it is the responder consuming the a/b/operation slave channels and producing the result master channel. It is a drop-in replacement for the vendor compare IP underneath the `synthesijer_fcomp64` wrapper, so generated designs synthesize without vendor cores. Its sequential content is a channel join, a two-stage elastic pipeline, and full ready/valid backpressure.

---
 rtl/synthesijer_fcomp64_pkg.sv | 31 +++
 rtl/synthesijer_fcomp64_classify.sv | 30 +++
 rtl/synthesijer_fcomp64_axis_core.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/synthesijer_fcomp64_pkg.sv
// Shared widths, opcodes and operand classification for the binary64 comparator.
// Build option: SYNTHESIJER_FCOMP64_DENORM_EN enables exact subnormal compare.
package synthesijer_fcomp64_pkg;

    localparam int FCMP_DATA_W = 64;
    localparam int FCMP_OP_W   = 8;
    localparam int FCMP_RES_W  = 8;

    localparam logic [2:0] FCMP_UN = 3'd0;
    localparam logic [2:0] FCMP_LT = 3'd1;
    localparam logic [2:0] FCMP_EQ = 3'd2;
    localparam logic [2:0] FCMP_LE = 3'd3;
    localparam logic [2:0] FCMP_GT = 3'd4;
    localparam logic [2:0] FCMP_NE = 3'd5;
    localparam logic [2:0] FCMP_GE = 3'd6;
    localparam logic [2:0] FCMP_CC = 3'd7;

    // Bit positions inside the condition-code result {UN, GT, LT, EQ}
    localparam int CC_EQ = 0;
    localparam int CC_LT = 1;
    localparam int CC_GT = 2;
    localparam int CC_UN = 3;

    typedef struct packed {
        logic        nan;
        logic        zero;
        logic        sign;
        logic [62:0] mag;
    } fcmp_class_t;

endpackage

// File: rtl/synthesijer_fcomp64_classify.sv
// Combinational binary64 operand classifier (NaN, zero, sign, magnitude).
// SYNTHESIJER_FCOMP64_DENORM_EN keeps subnormals; otherwise they flush to signed zero.
module synthesijer_fcomp64_classify
    import synthesijer_fcomp64_pkg::*;
(
    input  logic [FCMP_DATA_W-1:0] data,
    output logic                   nan,
    output logic                   zero,
    output logic                   sign,
    output logic [62:0]            mag
);

    logic [10:0] exp_f;
    logic [51:0] man_f;

    assign exp_f = data[62:52];
    assign man_f = data[51:0];
    assign sign  = data[63];
    assign nan   = (&exp_f) & (|man_f);

`ifdef SYNTHESIJER_FCOMP64_DENORM_EN
    assign zero = ~|data[62:0];
    assign mag  = data[62:0];
`else
    // Zero exponent means zero or subnormal; both become a signed zero
    assign zero = ~|exp_f;
    assign mag  = zero ? 63'd0 : data[62:0];
`endif

endmodule

// File: rtl/synthesijer_fcomp64_axis_core.sv
// AXI4-Stream binary64 comparator: 3-channel join into a 2-stage elastic pipeline.
// Subnormal handling selected by SYNTHESIJER_FCOMP64_DENORM_EN (see classifier).
module synthesijer_fcomp64_axis_core
    import synthesijer_fcomp64_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FCMP_DATA_W-1:0] s_axis_a_tdata,
    input  logic                   s_axis_a_tvalid,
    output logic                   s_axis_a_tready,
    input  logic [FCMP_DATA_W-1:0] s_axis_b_tdata,
    input  logic                   s_axis_b_tvalid,
    output logic                   s_axis_b_tready,
    input  logic [FCMP_OP_W-1:0]   s_axis_operation_tdata,
    input  logic                   s_axis_operation_tvalid,
    output logic                   s_axis_operation_tready,
    output logic [FCMP_RES_W-1:0]  m_axis_result_tdata,
    output logic                   m_axis_result_tvalid,
    input  logic                   m_axis_result_tready
);

    fcmp_class_t cls_a;
    fcmp_class_t cls_b;
    fcmp_class_t c1_a;
    fcmp_class_t c1_b;
    logic [2:0]  op1;
    logic        v1;
    logic        v2;
    logic        ready1;
    logic        s_ready;
    logic        accept;

    logic [FCMP_RES_W-1:0] res_d;
    logic [FCMP_RES_W-1:0] res_q;

    synthesijer_fcomp64_classify u_cls_a (
        .data (s_axis_a_tdata),
        .nan  (cls_a.nan),
        .zero (cls_a.zero),
        .sign (cls_a.sign),
        .mag  (cls_a.mag)
    );

    synthesijer_fcomp64_classify u_cls_b (
        .data (s_axis_b_tdata),
        .nan  (cls_b.nan),
        .zero (cls_b.zero),
        .sign (cls_b.sign),
        .mag  (cls_b.mag)
    );

    assign ready1  = ~v2 | m_axis_result_tready;
    assign s_ready = ~v1 | ready1;
    assign accept  = s_ready & s_axis_a_tvalid
                   & s_axis_b_tvalid & s_axis_operation_tvalid;

    assign s_axis_a_tready         = s_ready;
    assign s_axis_b_tready         = s_ready;
    assign s_axis_operation_tready = s_ready;

    // Stage 1: classified operands and predicate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1   <= 1'b0;
            c1_a <= '0;
            c1_b <= '0;
            op1  <= FCMP_UN;
        end else if (s_ready) begin
            v1 <= accept;
            if (accept) begin
                c1_a <= cls_a;
                c1_b <= cls_b;
                op1  <= s_axis_operation_tdata[5:3];
            end
        end
    end

    logic un;
    logic both_zero;
    logic mag_lt;
    logic mag_eq;
    logic lt;
    logic eq;
    logic gt;

    assign un        = c1_a.nan | c1_b.nan;
    assign both_zero = c1_a.zero & c1_b.zero;
    assign mag_lt    = c1_a.mag < c1_b.mag;
    assign mag_eq    = c1_a.mag == c1_b.mag;

    always_comb begin
        lt = 1'b0;
        eq = 1'b0;
        gt = 1'b0;
        if (!un) begin
            if (both_zero) begin
                eq = 1'b1;
            end else if (c1_a.sign != c1_b.sign) begin
                lt = c1_a.sign;
                gt = c1_b.sign;
            end else begin
                // Negative operands reverse the magnitude order
                eq = mag_eq;
                lt = c1_a.sign ? (~mag_lt & ~mag_eq) : mag_lt;
                gt = c1_a.sign ? mag_lt : (~mag_lt & ~mag_eq);
            end
        end
    end

    always_comb begin
        res_d = '0;
        unique case (op1)
            FCMP_UN: res_d[0] = un;
            FCMP_LT: res_d[0] = lt;
            FCMP_EQ: res_d[0] = eq;
            FCMP_LE: res_d[0] = lt | eq;
            FCMP_GT: res_d[0] = gt;
            FCMP_NE: res_d[0] = ~eq;
            FCMP_GE: res_d[0] = gt | eq;
            FCMP_CC: begin
                res_d[CC_EQ] = eq;
                res_d[CC_LT] = lt;
                res_d[CC_GT] = gt;
                res_d[CC_UN] = un;
            end
            default: res_d = '0;
        endcase
    end

    // Stage 2: output register, held while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2    <= 1'b0;
            res_q <= '0;
        end else if (ready1) begin
            v2 <= v1;
            if (v1) begin
                res_q <= res_d;
            end
        end
    end

    assign m_axis_result_tvalid = v2;
    assign m_axis_result_tdata  = res_q;

endmodule
